// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C bus master (START, address + R/W, ACK, one data byte, STOP)
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   newd     request strobe, accepted only while idle
//   op       1 = read, 0 = write
//   addr     7-bit slave address
//   din      write data byte
//   scl      I2C clock (driven high when idle)
//   sda      I2C data, push-pull when driven, high-Z when released
//   dout     read data byte
//   busy     transaction in progress
//   ack_err  slave NACK on the address or write-data ACK slot (held until next request)
//   done     one-cycle pulse at transaction end
//
// Optional feature: define I2C_ACK_RETRY_EN to retry a NACKed address up to RETRY_MAX times.
module i2c_master #(
    parameter int sys_freq = 40000000,
    parameter int i2c_freq = 100000
`ifdef I2C_ACK_RETRY_EN
    ,
    parameter int RETRY_MAX = 3
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       op,
    input  logic [6:0] addr,
    input  logic [7:0] din,
    output logic       scl,
    inout  wire        sda,
    output logic [7:0] dout,
    output logic       busy,
    output logic       ack_err,
    output logic       done
);
    localparam int clk_count4 = sys_freq / i2c_freq;
    localparam int clk_count1 = clk_count4 / 4;
    localparam int CW = $clog2(clk_count4);
    localparam logic [CW-1:0] C_LAST = CW'(clk_count4 - 1);
    localparam logic [CW-1:0] C_Q1 = CW'(clk_count1);
    localparam logic [CW-1:0] C_Q2 = CW'(2 * clk_count1);

    typedef enum logic [3:0] {
        IDLE, START, WRITE_ADDR, ACK1, WRITE_DATA, ACK2, READ_DATA, MASTER_ACK, STOP
    } state_t;

    state_t state, state_n;
    logic [CW-1:0] count;
    logic [2:0] bitn;
    logic [7:0] sh, rx, din_q;
    logic [6:0] addr_q;
    logic op_q, addr_nack, hold_en, hold_val, sda_en, sda_val;
    logic last, samp, q0, hi, retry_go, give_up;

    assign last = count == C_LAST;
    assign samp = count == C_Q2;
    assign q0 = count < C_Q1;
    assign hi = count >= C_Q2;
    assign busy = state != IDLE;
    assign sda = sda_en ? sda_val : 1'bz;

`ifdef I2C_ACK_RETRY_EN
    logic [3:0] retry_cnt;
    assign retry_go = addr_nack && retry_cnt < 4'(RETRY_MAX);
    assign give_up = retry_cnt == 4'(RETRY_MAX);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            retry_cnt <= '0;
        else if (state == IDLE && newd)
            retry_cnt <= '0;
        else if (state == STOP && last && retry_go)
            retry_cnt <= retry_cnt + 1'b1;
    end
`else
    assign retry_go = 1'b0;
    assign give_up = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        scl = 1'b1;
        sda_en = 1'b0;
        sda_val = 1'b1;
        case (state)
            IDLE:       if (newd) state_n = START;
            START: begin
                sda_en = 1'b1;
                sda_val = !hi;
                if (last) state_n = WRITE_ADDR;
            end
            WRITE_ADDR: begin
                sda_en = 1'b1;
                sda_val = sh[7];
                if (last && bitn == 3'd7) state_n = ACK1;
            end
            ACK1:       if (last) state_n = addr_nack ? STOP : (op_q ? READ_DATA : WRITE_DATA);
            WRITE_DATA: begin
                sda_en = 1'b1;
                sda_val = sh[7];
                if (last && bitn == 3'd7) state_n = ACK2;
            end
            ACK2:       if (last) state_n = STOP;
            READ_DATA:  if (last && bitn == 3'd7) state_n = MASTER_ACK;
            MASTER_ACK: begin
                sda_en = 1'b1;
                if (last) state_n = STOP;
            end
            STOP: begin
                scl = !q0;
                sda_en = 1'b1;
                sda_val = hi;
                if (last) state_n = retry_go ? START : IDLE;
            end
            default:    state_n = IDLE;
        endcase
        // Bit slots: SCL low for the first half; SDA keeps the previous value
        // through q0 so it only ever changes at the start of q1.
        if (state inside {WRITE_ADDR, ACK1, WRITE_DATA, ACK2, READ_DATA, MASTER_ACK}) begin
            scl = hi;
            if (q0) begin
                sda_en = hold_en;
                sda_val = hold_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            bitn <= '0;
            sh <= '0;
            rx <= '0;
            din_q <= '0;
            addr_q <= '0;
            op_q <= 1'b0;
            addr_nack <= 1'b0;
            hold_en <= 1'b0;
            hold_val <= 1'b1;
            dout <= '0;
            ack_err <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= state == STOP && last && !retry_go;
            hold_en <= sda_en;
            hold_val <= sda_val;
            count <= (state == IDLE || last) ? '0 : count + 1'b1;
            if (state == IDLE && newd) begin
                addr_q <= addr;
                op_q <= op;
                din_q <= din;
                ack_err <= 1'b0;
                addr_nack <= 1'b0;
            end
            if (last && state inside {WRITE_ADDR, WRITE_DATA, READ_DATA})
                bitn <= bitn + 1'b1;
            if (state == START && last)
                sh <= {addr_q, op_q};
            else if (state == ACK1 && last)
                sh <= din_q;
            else if (last && state inside {WRITE_ADDR, WRITE_DATA})
                sh <= {sh[6:0], 1'b0};
            if (state == READ_DATA && samp)
                rx <= {rx[6:0], sda};
            if (state == READ_DATA && last && bitn == 3'd7)
                dout <= rx;
            if (state == ACK1 && samp)
                addr_nack <= sda;
            if (state == ACK1 && last && addr_nack && give_up)
                ack_err <= 1'b1;
            if (state == ACK2 && samp && sda)
                ack_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: randomized scoreboard bench for i2c_master with a behavioural bus slave
module tb_i2c_master;
    // SCL scaled to 1 MHz so a 20-bit transaction is 800 cycles.
    localparam int SYS = 40000000;
    localparam int I2C = 1000000;
    localparam int C4 = SYS / I2C;
    localparam int SDLY = 3 * C4 / 8;
    localparam int FULL_LAT = 20 * C4;
`ifdef I2C_ACK_RETRY_EN
    localparam int NACK_TRIES = 4;
`else
    localparam int NACK_TRIES = 1;
`endif
    localparam int NACK_LAT = 11 * C4 * NACK_TRIES;

    logic clk = 0, rst = 0, newd = 0, op = 0;
    logic [6:0] addr = 0;
    logic [7:0] din = 0;
    logic scl, busy, ack_err, done;
    logic [7:0] dout;
    wire sda;
    logic s_low = 0;

    pullup (sda);
    assign sda = s_low ? 1'b0 : 1'bz;

    i2c_master #(.sys_freq(SYS), .i2c_freq(I2C)) dut (
        .clk(clk), .rst(rst), .newd(newd), .op(op), .addr(addr), .din(din),
        .scl(scl), .sda(sda), .dout(dout), .busy(busy), .ack_err(ack_err), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slave: acks any address when present, memory preset to mem[i]=i.
    logic scl_d = 1, sda_d = 1, pend = 0, s_mack = 0, mem_ok = 0;
    logic s_present = 1, s_dnack = 0;
    int ph = 0, nb = 0, tmr = 0, start_cnt = 0, stop_cnt = 0;
    logic [7:0] sh8 = 0, s_ab = 0, rbyte = 0;
    logic [7:0] s_mem [128];

    always @(posedge clk) begin
        scl_d <= scl;
        sda_d <= sda;
        if (!rst) begin
            ph <= 0;
            s_low <= 0;
            tmr <= 0;
            if (!mem_ok) begin
                for (int i = 0; i < 128; i++) s_mem[i] <= 8'(i);
                mem_ok <= 1;
            end
        end else begin
            if (tmr == 1) s_low <= pend;
            if (tmr != 0) tmr <= tmr - 1;
            if (scl && scl_d && sda_d && !sda) begin
                start_cnt <= start_cnt + 1;
                ph <= 1;
                nb <= 0;
            end else if (scl && scl_d && !sda_d && sda) begin
                stop_cnt <= stop_cnt + 1;
                ph <= 0;
            end else if (scl && !scl_d) begin
                if (ph == 1 || ph == 3) begin
                    sh8 <= {sh8[6:0], sda};
                    nb <= nb + 1;
                end
                if (ph == 5) nb <= nb + 1;
                if (ph == 6) s_mack <= sda;
            end else if (!scl && scl_d) begin
                s_low <= 0;
                tmr <= SDLY;
                pend <= 0;
                case (ph)
                    1: if (nb == 8) begin
                        ph <= 2;
                        s_ab <= sh8;
                        pend <= s_present;
                        nb <= 0;
                    end
                    2: if (!s_present) ph <= 0;
                       else if (s_ab[0]) begin
                           ph <= 5;
                           rbyte <= s_mem[s_ab[7:1]];
                           pend <= !s_mem[s_ab[7:1]][7];
                       end else ph <= 3;
                    3: if (nb == 8) begin
                        ph <= 4;
                        s_mem[s_ab[7:1]] <= sh8;
                        pend <= !s_dnack;
                    end
                    5: if (nb == 8) ph <= 6;
                       else pend <= !rbyte[3'(7 - nb)];
                    default: ph <= 0;
                endcase
            end
        end
    end

    typedef struct {
        logic [7:0] ab;
        logic err;
        logic [7:0] dout;
        int lat, t0, st0, sp0, dr0, tries;
        logic wr_ok, rd_ok;
        logic [6:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int total = 0, bad = 0, drops = 0;
    logic busy_p = 0;
    logic [7:0] ref_mem [128];
    logic [7:0] ref_dout = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        int lat;
        forever begin
            @(negedge clk);
            if (!rst) busy_p = 0;
            else begin
                if (busy_p && !busy) drops++;
                busy_p = busy;
                if (done) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending request", cyc);
                    end else begin
                        e = sb.pop_front();
                        lat = cyc - e.t0;
                        total++;
                        if (lat < e.lat - 1 || lat > e.lat + 1) begin
                            bad++;
                            $display("FAIL latency: got %0d cycles, required %0d +/-1", lat, e.lat);
                        end
                        chk("ack_err", 32'(ack_err), 32'(e.err));
                        chk("dout", 32'(dout), 32'(e.dout));
                        chk("busy_at_done", 32'(busy), 0);
                        chk("addr_byte", 32'(s_ab), 32'(e.ab));
                        chk("start_count", 32'(start_cnt - e.st0), 32'(e.tries));
                        chk("stop_count", 32'(stop_cnt - e.sp0), 32'(e.tries));
                        chk("busy_drops", 32'(drops - e.dr0), 1);
                        if (e.wr_ok) chk("slave_mem", 32'(s_mem[e.a]), 32'(e.d));
                        if (e.rd_ok) chk("master_nack_bit", 32'(s_mack), 1);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [6:0] a, input logic o, input logic [7:0] d,
                         input logic pres, input logic dn, input bit push);
        exp_t e;
        s_present = pres;
        s_dnack = dn;
        @(negedge clk);
        addr = a; op = o; din = d; newd = 1;
        @(negedge clk);
        newd = 0; addr = 7'($urandom); op = 1'($urandom); din = 8'($urandom);
        if (push) begin
            e.t0 = cyc; e.st0 = start_cnt; e.sp0 = stop_cnt; e.dr0 = drops;
            e.ab = {a, o}; e.a = a; e.d = d;
            e.tries = pres ? 1 : NACK_TRIES;
            e.lat = pres ? FULL_LAT : NACK_LAT;
            e.err = !pres || (!o && dn);
            e.wr_ok = pres && !o;
            e.rd_ok = pres && o;
            if (pres && o) ref_dout = ref_mem[a];
            if (pres && !o) ref_mem[a] = d;
            e.dout = ref_dout;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 3 * NACK_LAT) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d requests pending after %0d cycles, required 0", sb.size(), n);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        chk("reset_scl", 32'(scl), 1);
        chk("reset_sda", 32'(sda), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_dout", 32'(dout), 0);
        chk("reset_ack_err", 32'(ack_err), 0);
        chk("reset_done", 32'(done), 0);
        rst = 1;
        @(negedge clk);

        issue(7'h12, 1, 8'h00, 1, 0, 1); wait_done();
        issue(7'h12, 0, 8'h55, 1, 0, 1); wait_done();
        issue(7'h12, 1, 8'h00, 1, 0, 1); wait_done();

        issue(7'h7F, 0, 8'hC3, 0, 0, 1); wait_done();
        chk("ack_err_held", 32'(ack_err), 1);

        issue(7'h33, 0, 8'hA5, 1, 0, 1);
        repeat (100) @(negedge clk);
        addr = 7'h44; din = 8'h0F; op = 0; newd = 1;
        @(negedge clk);
        newd = 0;
        wait_done();
        chk("ignored_req_mem", 32'(s_mem[7'h44]), 32'(ref_mem[7'h44]));

        issue(7'h21, 0, 8'h99, 1, 0, 0);
        repeat (300) @(negedge clk);
        #2 rst = 0;
        #1;
        chk("abort_scl", 32'(scl), 1);
        chk("abort_sda", 32'(sda), 1);
        chk("abort_busy", 32'(busy), 0);
        ref_dout = 0;
        repeat (3) @(negedge clk);
        chk("abort_dout", 32'(dout), 32'(ref_dout));
        chk("abort_done", 32'(done), 0);
        rst = 1;
        @(negedge clk);
        issue(7'h21, 0, 8'h99, 1, 0, 1); wait_done();

        for (int i = 0; i < 14; i++) begin
            issue(7'($urandom), 1'($urandom), 8'($urandom),
                  $urandom_range(0, 5) != 0, $urandom_range(0, 4) == 0, 1);
            wait_done();
        end

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-byte I2C bus master; the initiator for the team's single-byte I2C slave. Ties to it over `scl`/`sda` in the top-level testbench environment.
- Per request: START, 7-bit address plus R/W bit, slave ACK check, one data byte written or read, STOP.
- Uses the same 4-quarter bit timing as the slave (40 MHz system clock, 100 kHz SCL).

Parameters:
- sys_freq, 40000000, system clock frequency in Hz.
- i2c_freq, 100000, SCL frequency in Hz.
- clk_count4, sys_freq/i2c_freq (400), system cycles per bit period.
- clk_count1, clk_count4/4 (100), system cycles per quarter.
- RETRY_MAX, 3, address retries (used only with I2C_ACK_RETRY_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- newd  input  1  request strobe, sampled in IDLE only.
- op  input  1  1 = read, 0 = write.
- addr  input  7  slave address.
- din  input  8  write data.
- scl  output  1  I2C clock.
- sda  inout  1  I2C data; push-pull when enabled, high-Z when released.
- dout  output  8  read data.
- busy  output  1  transaction in progress.
- ack_err  output  1  slave NACK on the address or write-data ACK slot.
- done  output  1  one-cycle pulse at transaction end.

Behaviour:
- Reset (rst=0, asynchronous):
  - scl=1, sda released, dout=0, busy=0, ack_err=0, done=0.
  - state=IDLE, bit and quarter counters cleared.
  - Reset mid-transfer aborts immediately; no STOP is generated.
- Quarter counter:
  - Counts 0..399 while busy, wraps to 0 at 399.
  - Quarter q = count/100.
  - Data bits: scl=0 in q0 and q1, scl=1 in q2 and q3.
  - Master changes sda at count 100 (q1 start).
  - Master samples sda at count 200.
- IDLE:
  - scl=1, sda released.
  - newd=1 latches {addr, op} and din, sets busy=1 and ack_err=0, goes to START.
  - newd while busy is ignored.
- START (one bit period): q0–q1 sda=1 and scl=1; q2–q3 sda=0 and scl=1.
- WRITE_ADDR (8 bits): shifts out {addr, op}, MSB first.
- ACK1: release sda; sample at count 200.
  - Sample 1 → ack_err=1, go to STOP.
  - Sample 0 and op=1 → READ_DATA.
  - Sample 0 and op=0 → WRITE_DATA.
- WRITE_DATA (8 bits): din MSB first. Then ACK2: release sda and sample; 1 → ack_err=1. Then STOP.
- READ_DATA (8 bits):
  - sda released; shift sampled bits MSB first into a shift register.
  - dout is loaded from it at the end of bit 7.
- MASTER_ACK: drive sda=1 (NACK, last byte) for one bit period, then STOP.
- STOP (one bit period): q0 sda=0 and scl=0; q1 sda=0 and scl=1; q2–q3 sda=1 and scl=1.
- Completion: after count 399 of STOP, done=1 for one cycle, busy=0, return to IDLE.
- ack_err is held until the next accepted newd.
- Latency from newd accept to done: 20 bit periods (8000 cycles) ±1 cycle, for both a full write and a full read. An address NACK takes 11 periods.

Optional Feature:
- Macro: I2C_ACK_RETRY_EN.
- Defined:
  - An address NACK in ACK1 goes to STOP, then re-enters START, up to RETRY_MAX times.
  - busy stays 1 throughout and no done pulse is issued between attempts.
  - ack_err=1 is set only after the final failed attempt.
  - A 4-bit retry counter is cleared on newd accept.
- Undefined: a NACK sets ack_err immediately; no retry logic is present.

Test Plan:
- Write, slave acks:
  - Stimulus: addr=0x12, op=0, din=0x55.
  - Response: sda sequence START, 0x24, ACK, 0x55, ACK, STOP; done after 8000±1 cycles; ack_err=0; slave mem[0x12]=0x55.
- Read after slave reset:
  - Stimulus: addr=0x12, op=1.
  - Response: dout=0x12, MASTER_ACK slot drives sda=1, ack_err=0, slave ack_err=0, done pulse.
- No slave at address:
  - Stimulus: addr=0x7F with the slave disconnected; bench pulls sda high.
  - Response: ack_err=1, STOP generated, done at 11 bit periods (macro undefined).
- Request while busy:
  - Stimulus: assert newd at cycle 1000 of an active write.
  - Response: request ignored; only one done pulse; latched din unchanged.
- Reset mid-transfer:
  - Stimulus: rst=0 at cycle 3000.
  - Response: scl=1, sda high-Z, busy=0 within the same cycle (asynchronous); a new write completes normally after reset.
- Retry:
  - Stimulus: I2C_ACK_RETRY_EN defined, slave absent.
  - Response: 4 START/STOP pairs, single done pulse, ack_err=1, busy continuous.
